// File: rtl/arb_req_client.sv
// Requester front end for a two-channel request/grant arbiter.
// Accepts jobs over valid/ready, requests the arbiter, and issues one beat per granted cycle.
//
// Ports (channel x in {0,1}):
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   job_valid_x/len_x     : job offer and its beat count
//   job_ready_x           : channel idle, can take a job
//   gnt_x / req_x         : arbiter grant in / request out
//   beat_x                : transfer beat this cycle
//   done_x / timeout_x    : one-cycle pulses, job completed / abandoned

module arb_req_chan #(
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             job_valid_i,
   input  logic [LEN_W-1:0] job_len_i,
   output logic             job_ready_o,
   input  logic             gnt_i,
   output logic             req_o,
   output logic             beat_o,
   output logic             done_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_REL
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [TO_W-1:0]  wait_q, wait_d;
   logic             done_q, done_d;
   logic             to_q, to_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         wait_q  <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   assign job_ready_o = (state_q == S_IDLE);
   assign req_o       = (state_q == S_REQ) || (state_q == S_XFER);
   assign beat_o      = req_o && gnt_i;
   assign done_o      = done_q;
   assign timeout_o   = to_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      wait_d  = wait_q;
      done_d  = 1'b0;
      to_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (job_valid_i) begin
               rem_d  = job_len_i;
               wait_d = '0;
               if (job_len_i != '0) begin
                  state_d = S_REQ;
               end else begin
                  // empty job completes without touching the arbiter
                  state_d = S_REL;
                  done_d  = 1'b1;
               end
            end
         end
         S_REQ: begin
            // a grant on the last wait cycle still wins over the timeout
            if (gnt_i) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = S_REL;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_XFER;
               end
            end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
               state_d = S_REL;
               to_d    = 1'b1;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         S_XFER: begin
            if (gnt_i) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = S_REL;
                  done_d  = 1'b1;
               end
            end
         end
         S_REL: begin
            // hold off the next job until the registered grant has dropped
            if (!gnt_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

module arb_req_client #(
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             job_valid_0,
   input  logic [LEN_W-1:0] job_len_0,
   output logic             job_ready_0,
   input  logic             gnt_0,
   output logic             req_0,
   output logic             beat_0,
   output logic             done_0,
   output logic             timeout_0,
   input  logic             job_valid_1,
   input  logic [LEN_W-1:0] job_len_1,
   output logic             job_ready_1,
   input  logic             gnt_1,
   output logic             req_1,
   output logic             beat_1,
   output logic             done_1,
   output logic             timeout_1
);

   arb_req_chan #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_ch0 (
      .clk_i       (clock),
      .rst_i       (reset),
      .job_valid_i (job_valid_0),
      .job_len_i   (job_len_0),
      .job_ready_o (job_ready_0),
      .gnt_i       (gnt_0),
      .req_o       (req_0),
      .beat_o      (beat_0),
      .done_o      (done_0),
      .timeout_o   (timeout_0)
   );

   arb_req_chan #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_ch1 (
      .clk_i       (clock),
      .rst_i       (reset),
      .job_valid_i (job_valid_1),
      .job_len_i   (job_len_1),
      .job_ready_o (job_ready_1),
      .gnt_i       (gnt_1),
      .req_o       (req_1),
      .beat_o      (beat_1),
      .done_o      (done_1),
      .timeout_o   (timeout_1)
   );

endmodule

// File: tb/tb_arb_req_client.sv
// Testbench for arb_req_client: directed steps with a per-channel job scoreboard.
// Arbiter model per channel: grant follows req one cycle later, or is forced.

module tb_arb_req_client;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       job_valid_0 = 1'b0;
   logic [3:0] job_len_0 = 4'd0;
   logic       job_ready_0;
   logic       gnt_0 = 1'b0;
   logic       req_0, beat_0, done_0, timeout_0;
   logic       job_valid_1 = 1'b0;
   logic [3:0] job_len_1 = 4'd0;
   logic       job_ready_1;
   logic       gnt_1 = 1'b0;
   logic       req_1, beat_1, done_1, timeout_1;

   // arbiter model controls
   logic am0 = 1'b0, gf0 = 1'b0;
   logic am1 = 1'b0, gf1 = 1'b0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int beats;
      bit done;
      bit to;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   bc0 = 0;
   int   bc1 = 0;

   arb_req_client dut (
      .clock       (clock),
      .reset       (reset),
      .job_valid_0 (job_valid_0),
      .job_len_0   (job_len_0),
      .job_ready_0 (job_ready_0),
      .gnt_0       (gnt_0),
      .req_0       (req_0),
      .beat_0      (beat_0),
      .done_0      (done_0),
      .timeout_0   (timeout_0),
      .job_valid_1 (job_valid_1),
      .job_len_1   (job_len_1),
      .job_ready_1 (job_ready_1),
      .gnt_1       (gnt_1),
      .req_1       (req_1),
      .beat_1      (beat_1),
      .done_1      (done_1),
      .timeout_1   (timeout_1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      gnt_0 <= am0 ? req_0 : gf0;
      gnt_1 <= am1 ? req_1 : gf1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sb_end(input int ch, input logic d, input logic t, input int bc);
      exp_t e;
      if (ch == 0 ? q0.size() == 0 : q1.size() == 0) begin
         chkn($sformatf("sb%0d_unexpected_end", ch), 1, 0);
      end else begin
         e = (ch == 0) ? q0.pop_front() : q1.pop_front();
         chkn($sformatf("sb%0d_beats", ch), bc, e.beats);
         chk1($sformatf("sb%0d_done", ch), d, e.done);
         chk1($sformatf("sb%0d_timeout", ch), t, e.to);
      end
   endtask

   // advance one cycle, sample at negedge, feed the scoreboard
   task automatic tick();
      @(negedge clock);
      if (beat_0 === 1'b1) bc0++;
      if (beat_1 === 1'b1) bc1++;
      if (done_0 || timeout_0) begin
         sb_end(0, done_0, timeout_0, bc0);
         bc0 = 0;
      end
      if (done_1 || timeout_1) begin
         sb_end(1, done_1, timeout_1, bc1);
         bc1 = 0;
      end
   endtask

   task automatic job0(input logic [3:0] len);
      job_valid_0 = 1'b1;
      job_len_0   = len;
      tick();
      job_valid_0 = 1'b0;
      job_len_0   = 4'hA;
   endtask

   task automatic wait_idle(input int ch, input int bound, input string tag);
      int n;
      n = 0;
      while (!((ch == 0) ? job_ready_0 : job_ready_1) && n < bound) begin
         tick();
         n++;
      end
      chk1(tag, (ch == 0) ? job_ready_0 : job_ready_1, 1'b1);
   endtask

   task automatic wait_done0(input int bound, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!done_0 && n < bound);
      chk1(tag, done_0, 1'b1);
   endtask

   initial begin
      int rc, tc;
      exp_t e;

      // reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk1("rst_ready0", job_ready_0, 1'b1);
      chk1("rst_ready1", job_ready_1, 1'b1);
      chk1("rst_req0", req_0, 1'b0);
      chk1("rst_done0", done_0, 1'b0);
      chk1("rst_to1", timeout_1, 1'b0);

      // basic transfer, grant follows req
      am0 = 1'b1;
      e = '{3, 1'b1, 1'b0};
      q0.push_back(e);
      job0(4'd3);
      chk1("b_c1_req", req_0, 1'b1);
      chk1("b_c1_beat", beat_0, 1'b0);
      chk1("b_c1_ready", job_ready_0, 1'b0);
      for (int c = 2; c <= 7; c++) begin
         tick();
         chk1($sformatf("b_c%0d_req", c), req_0, c <= 4);
         chk1($sformatf("b_c%0d_beat", c), beat_0, c >= 2 && c <= 4);
         chk1($sformatf("b_c%0d_done", c), done_0, c == 5);
         chk1($sformatf("b_c%0d_ready", c), job_ready_0, c == 7);
      end

      // timeout with grant held low
      am0 = 1'b0;
      gf0 = 1'b0;
      e = '{0, 1'b0, 1'b1};
      q0.push_back(e);
      job0(4'd2);
      rc = 0;
      tc = 0;
      for (int n = 0; n < 40 && !job_ready_0; n++) begin
         if (req_0) rc++;
         if (timeout_0) tc++;
         tick();
      end
      chkn("to_req_cycles", rc, 16);
      chkn("to_pulses", tc, 1);
      chk1("to_idle", job_ready_0, 1'b1);

      // grant arrives on the 16th REQ cycle
      e = '{2, 1'b1, 1'b0};
      q0.push_back(e);
      job0(4'd2);
      for (int c = 2; c <= 15; c++) tick();
      gf0 = 1'b1;
      tick();
      chk1("lw_c16_beat", beat_0, 1'b1);
      chk1("lw_c16_to", timeout_0, 1'b0);
      tick();
      chk1("lw_c17_beat", beat_0, 1'b1);
      tick();
      chk1("lw_c18_done", done_0, 1'b1);
      chk1("lw_c18_to", timeout_0, 1'b0);
      gf0 = 1'b0;
      wait_idle(0, 5, "lw_idle");

      // zero length
      am0 = 1'b1;
      e = '{0, 1'b1, 1'b0};
      q0.push_back(e);
      job0(4'd0);
      chk1("z_done", done_0, 1'b1);
      chk1("z_req", req_0, 1'b0);
      tick();
      chk1("z_req2", req_0, 1'b0);
      chk1("z_ready", job_ready_0, 1'b1);

      // maximum length, grant held high
      am0 = 1'b0;
      gf0 = 1'b1;
      e = '{15, 1'b1, 1'b0};
      q0.push_back(e);
      job0(4'd15);
      wait_done0(30, "max_done");
      chk1("max_rel_req", req_0, 1'b0);
      chk1("max_rel_beat", beat_0, 1'b0);
      gf0 = 1'b0;
      wait_idle(0, 5, "max_idle");

      // both channels, channel 0 served first
      am0 = 1'b1;
      am1 = 1'b0;
      gf1 = 1'b0;
      e = '{4, 1'b1, 1'b0};
      q0.push_back(e);
      e = '{2, 1'b1, 1'b0};
      q1.push_back(e);
      job_valid_1 = 1'b1;
      job_len_1   = 4'd2;
      job0(4'd4);
      job_valid_1 = 1'b0;
      job_len_1   = 4'd9;
      rc = 0;
      for (int n = 0; n < 12 && !done_0; n++) begin
         if (req_1 !== 1'b1 || beat_1 !== 1'b0) rc++;
         tick();
      end
      chk1("cc_done0", done_0, 1'b1);
      chkn("cc_ch1_waiting", rc, 0);
      am1 = 1'b1;
      wait_idle(1, 20, "cc_idle1");
      wait_idle(0, 20, "cc_idle0");
      chkn("cc_q1_empty", q1.size(), 0);

      // reset in XFER with two beats remaining
      am0 = 1'b0;
      gf0 = 1'b1;
      job0(4'd4);
      tick();
      tick();
      chk1("rx_c3_beat", beat_0, 1'b1);
      reset = 1'b1;
      gf0 = 1'b0;
      tick();
      reset = 1'b0;
      bc0 = 0;
      chk1("rx_req", req_0, 1'b0);
      chk1("rx_beat", beat_0, 1'b0);
      chk1("rx_done", done_0, 1'b0);
      chk1("rx_to", timeout_0, 1'b0);
      chk1("rx_ready", job_ready_0, 1'b1);
      tick();
      chk1("rx_done_after", done_0, 1'b0);
      chk1("rx_ready_after", job_ready_0, 1'b1);

      // grant withdrawn mid-transfer for 3 cycles
      gf0 = 1'b1;
      e = '{5, 1'b1, 1'b0};
      q0.push_back(e);
      job0(4'd5);
      tick();
      gf0 = 1'b0;
      for (int c = 3; c <= 5; c++) begin
         tick();
         chk1($sformatf("gw_c%0d_req", c), req_0, 1'b1);
         chk1($sformatf("gw_c%0d_beat", c), beat_0, 1'b0);
      end
      gf0 = 1'b1;
      wait_done0(10, "gw_done");
      gf0 = 1'b0;
      wait_idle(0, 5, "gw_idle");

      chkn("q0_empty", q0.size(), 0);
      chkn("q1_empty", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
